// File: rtl/rs_issue_queue_if.sv
// Dispatch, CDB snoop and issue channels of the reservation-station issue queue.
// master = dispatch/CDB/execution side, slave = the queue itself.
interface rs_issue_queue_if #(
  parameter int unsigned NUM_RS_ENTRIES = 8,
  parameter int unsigned PHY_WIDTH      = 6,
  parameter int unsigned ROB_WIDTH      = 5,
  parameter int unsigned UOP_WIDTH      = 32
);
  localparam int unsigned CntW = $clog2(NUM_RS_ENTRIES + 1);

  logic                 dispatch_valid;
  logic                 dispatch_ready;
  logic [UOP_WIDTH-1:0] dispatch_uop;
  logic [ROB_WIDTH-1:0] dispatch_rob_idx;
  logic [PHY_WIDTH-1:0] dispatch_prd;
  logic [PHY_WIDTH-1:0] dispatch_prs1;
  logic [PHY_WIDTH-1:0] dispatch_prs2;
  logic                 dispatch_rs1_rdy;
  logic                 dispatch_rs2_rdy;

  logic                 cdb_valid;
  logic [PHY_WIDTH-1:0] cdb_tag;

  logic                 issue_valid;
  logic                 issue_ready;
  logic [UOP_WIDTH-1:0] issue_uop;
  logic [ROB_WIDTH-1:0] issue_rob_idx;
  logic [PHY_WIDTH-1:0] issue_prd;
  logic [PHY_WIDTH-1:0] issue_prs1;
  logic [PHY_WIDTH-1:0] issue_prs2;

  logic [CntW-1:0]      count;

  modport master (
    output dispatch_valid, dispatch_uop, dispatch_rob_idx, dispatch_prd,
           dispatch_prs1, dispatch_prs2, dispatch_rs1_rdy, dispatch_rs2_rdy,
           cdb_valid, cdb_tag, issue_ready,
    input  dispatch_ready, issue_valid, issue_uop, issue_rob_idx, issue_prd,
           issue_prs1, issue_prs2, count
  );

  modport slave (
    input  dispatch_valid, dispatch_uop, dispatch_rob_idx, dispatch_prd,
           dispatch_prs1, dispatch_prs2, dispatch_rs1_rdy, dispatch_rs2_rdy,
           cdb_valid, cdb_tag, issue_ready,
    output dispatch_ready, issue_valid, issue_uop, issue_rob_idx, issue_prd,
           issue_prs1, issue_prs2, count
  );
endinterface

// File: rtl/rs_issue_queue.sv
// Collapsing reservation-station issue queue: age-ordered storage, CDB wakeup,
// oldest-ready select with valid/ready issue handshake.
module rs_issue_queue #(
  parameter int unsigned NUM_RS_ENTRIES = 8,
  parameter int unsigned PHY_WIDTH      = 6,
  parameter int unsigned ROB_WIDTH      = 5,
  parameter int unsigned UOP_WIDTH      = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  rs_issue_queue_if.slave io_q
);
  localparam int unsigned CntW = $clog2(NUM_RS_ENTRIES + 1);
  localparam int unsigned IdxW = $clog2(NUM_RS_ENTRIES);

  typedef struct packed {
    logic [UOP_WIDTH-1:0] uop;
    logic [ROB_WIDTH-1:0] rob_idx;
    logic [PHY_WIDTH-1:0] prd;
    logic [PHY_WIDTH-1:0] prs1;
    logic [PHY_WIDTH-1:0] prs2;
    logic                 rs1_rdy;
    logic                 rs2_rdy;
  } entry_t;

  entry_t          r_ent     [NUM_RS_ENTRIES];
  entry_t          w_ent_nxt [NUM_RS_ENTRIES];
  entry_t          w_new;
  entry_t          w_out;
  entry_t          r_hold;
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_nxt;
  logic [CntW-1:0] w_wr_idx;
  logic            r_disp_rdy;
  logic            w_disp_fire;
  logic            w_iss_fire;
  logic            w_issue_valid;
  logic [IdxW-1:0] w_sel_idx;

  // Tag 0 is the hardwired-ready register; otherwise a matching CDB broadcast wakes the source.
  function automatic logic src_ready(input logic                 rdy,
                                     input logic [PHY_WIDTH-1:0] tag,
                                     input logic                 cdb_v,
                                     input logic [PHY_WIDTH-1:0] cdb_t);
    return rdy || (tag == '0) || (cdb_v && (cdb_t == tag));
  endfunction

  // Oldest-ready select: scan from the top so the lowest index wins.
  always_comb begin
    w_issue_valid = 1'b0;
    w_sel_idx     = '0;
    for (int i = NUM_RS_ENTRIES - 1; i >= 0; i--) begin
      if ((CntW'(i) < r_count) && r_ent[i].rs1_rdy && r_ent[i].rs2_rdy) begin
        w_issue_valid = 1'b1;
        w_sel_idx     = IdxW'(i);
      end
    end
  end

  assign w_out       = w_issue_valid ? r_ent[w_sel_idx] : r_hold;
  assign w_disp_fire = io_q.dispatch_valid && r_disp_rdy;
  assign w_iss_fire  = w_issue_valid && io_q.issue_ready;
  assign w_wr_idx    = r_count - CntW'(w_iss_fire);
  assign w_count_nxt = r_count + CntW'(w_disp_fire) - CntW'(w_iss_fire);

  always_comb begin
    w_new.uop     = io_q.dispatch_uop;
    w_new.rob_idx = io_q.dispatch_rob_idx;
    w_new.prd     = io_q.dispatch_prd;
    w_new.prs1    = io_q.dispatch_prs1;
    w_new.prs2    = io_q.dispatch_prs2;
    w_new.rs1_rdy = src_ready(io_q.dispatch_rs1_rdy, io_q.dispatch_prs1,
                              io_q.cdb_valid, io_q.cdb_tag);
    w_new.rs2_rdy = src_ready(io_q.dispatch_rs2_rdy, io_q.dispatch_prs2,
                              io_q.cdb_valid, io_q.cdb_tag);
  end

  // Collapse above the issued slot, apply wakeup, then drop in the dispatched entry.
  always_comb begin
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      if (w_iss_fire && (IdxW'(i) >= w_sel_idx) && (i < NUM_RS_ENTRIES - 1)) begin
        w_ent_nxt[i] = r_ent[(i + 1) % NUM_RS_ENTRIES];
      end else begin
        w_ent_nxt[i] = r_ent[i];
      end
      w_ent_nxt[i].rs1_rdy = src_ready(w_ent_nxt[i].rs1_rdy, w_ent_nxt[i].prs1,
                                       io_q.cdb_valid, io_q.cdb_tag);
      w_ent_nxt[i].rs2_rdy = src_ready(w_ent_nxt[i].rs2_rdy, w_ent_nxt[i].prs2,
                                       io_q.cdb_valid, io_q.cdb_tag);
      if (w_disp_fire && (CntW'(i) == w_wr_idx)) begin
        w_ent_nxt[i] = w_new;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count    <= '0;
      r_disp_rdy <= 1'b1;
      r_hold     <= '0;
      r_ent      <= '{default: '0};
    end else if (i_flush) begin
      r_count    <= '0;
      r_disp_rdy <= 1'b1;
      r_hold     <= w_out;
    end else begin
      r_count    <= w_count_nxt;
      r_disp_rdy <= (w_count_nxt < CntW'(NUM_RS_ENTRIES));
      r_hold     <= w_out;
      r_ent      <= w_ent_nxt;
    end
  end

  assign io_q.dispatch_ready = r_disp_rdy;
  assign io_q.count          = r_count;
  assign io_q.issue_valid    = w_issue_valid;
  assign io_q.issue_uop      = w_out.uop;
  assign io_q.issue_rob_idx  = w_out.rob_idx;
  assign io_q.issue_prd      = w_out.prd;
  assign io_q.issue_prs1     = w_out.prs1;
  assign io_q.issue_prs2     = w_out.prs2;
endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed and randomized checks of rs_issue_queue against an age-ordered list model.
module tb_rs_issue_queue;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  rs_issue_queue_if q_if ();

  rs_issue_queue dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_flush(flush),
    .io_q   (q_if)
  );

  typedef struct {
    logic [31:0] uop;
    logic [4:0]  rob;
    logic [5:0]  prd;
    logic [5:0]  prs1;
    logic [5:0]  prs2;
    bit          r1;
    bit          r2;
  } ent_t;

  ent_t mq[$];
  ent_t hold;
  int   checks = 0;
  int   failures = 0;

  logic       obs_iv;
  logic [4:0] obs_rob;
  logic [3:0] obs_cnt;
  logic       obs_drdy;

  function automatic ent_t zero_ent();
    ent_t e;
    e.uop = '0; e.rob = '0; e.prd = '0; e.prs1 = '0; e.prs2 = '0; e.r1 = 1'b0; e.r2 = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_disp(input logic [4:0] rob, input logic [5:0] p1, input bit r1,
                          input logic [5:0] p2, input bit r2);
    q_if.dispatch_valid   = 1'b1;
    q_if.dispatch_uop     = $urandom();
    q_if.dispatch_rob_idx = rob;
    q_if.dispatch_prd     = 6'($urandom());
    q_if.dispatch_prs1    = p1;
    q_if.dispatch_prs2    = p2;
    q_if.dispatch_rs1_rdy = r1;
    q_if.dispatch_rs2_rdy = r2;
  endtask

  task automatic set_cdb(input logic [5:0] t);
    q_if.cdb_valid = 1'b1;
    q_if.cdb_tag   = t;
  endtask

  // One clock: compare outputs with the model, advance the model, then clear one-shot inputs.
  task automatic tick();
    int   sel;
    bit   iv;
    bit   dfire;
    ent_t cur;
    ent_t ne;
    @(negedge clk);
    sel = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
    end
    iv  = (sel >= 0);
    cur = iv ? mq[sel] : hold;
    obs_iv   = q_if.issue_valid;
    obs_rob  = q_if.issue_rob_idx;
    obs_cnt  = q_if.count;
    obs_drdy = q_if.dispatch_ready;
    chk("count", 64'(q_if.count), 64'(mq.size()));
    chk("dispatch_ready", 64'(q_if.dispatch_ready), 64'(mq.size() < N));
    chk("issue_valid", 64'(q_if.issue_valid), 64'(iv));
    chk("issue_uop", 64'(q_if.issue_uop), 64'(cur.uop));
    chk("issue_rob_idx", 64'(q_if.issue_rob_idx), 64'(cur.rob));
    chk("issue_prd", 64'(q_if.issue_prd), 64'(cur.prd));
    chk("issue_prs1", 64'(q_if.issue_prs1), 64'(cur.prs1));
    chk("issue_prs2", 64'(q_if.issue_prs2), 64'(cur.prs2));
    if (rst) begin
      mq.delete();
      hold = zero_ent();
    end else if (flush) begin
      mq.delete();
      hold = cur;
    end else begin
      hold  = cur;
      dfire = q_if.dispatch_valid && (mq.size() < N);
      if (iv && q_if.issue_ready) mq.delete(sel);
      if (q_if.cdb_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].prs1 == q_if.cdb_tag) mq[i].r1 = 1'b1;
          if (mq[i].prs2 == q_if.cdb_tag) mq[i].r2 = 1'b1;
        end
      end
      if (dfire) begin
        ne.uop  = q_if.dispatch_uop;
        ne.rob  = q_if.dispatch_rob_idx;
        ne.prd  = q_if.dispatch_prd;
        ne.prs1 = q_if.dispatch_prs1;
        ne.prs2 = q_if.dispatch_prs2;
        ne.r1   = q_if.dispatch_rs1_rdy || (ne.prs1 == 0) ||
                  (q_if.cdb_valid && q_if.cdb_tag == ne.prs1);
        ne.r2   = q_if.dispatch_rs2_rdy || (ne.prs2 == 0) ||
                  (q_if.cdb_valid && q_if.cdb_tag == ne.prs2);
        mq.push_back(ne);
      end
    end
    @(posedge clk);
    #1;
    q_if.dispatch_valid = 1'b0;
    q_if.cdb_valid      = 1'b0;
    flush               = 1'b0;
    rst                 = 1'b0;
  endtask

  initial begin
    q_if.dispatch_valid   = 1'b0;
    q_if.dispatch_uop     = '0;
    q_if.dispatch_rob_idx = '0;
    q_if.dispatch_prd     = '0;
    q_if.dispatch_prs1    = '0;
    q_if.dispatch_prs2    = '0;
    q_if.dispatch_rs1_rdy = 1'b0;
    q_if.dispatch_rs2_rdy = 1'b0;
    q_if.cdb_valid        = 1'b0;
    q_if.cdb_tag          = '0;
    q_if.issue_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    hold = zero_ent();
    mq.delete();

    // Reset state
    tick();
    chk("rst_count", 64'(obs_cnt), 64'd0);
    chk("rst_drdy", 64'(obs_drdy), 64'd1);
    chk("rst_iv", 64'(obs_iv), 64'd0);

    // Three ready entries issue in order 0,1,2
    q_if.issue_ready = 1'b1;
    set_disp(5'd0, 6'd0, 1'b1, 6'd0, 1'b1); tick();
    set_disp(5'd1, 6'd1, 1'b1, 6'd2, 1'b1); tick();
    chk("t1_first", 64'(obs_rob), 64'd0);
    set_disp(5'd2, 6'd3, 1'b1, 6'd4, 1'b1); tick();
    chk("t1_second", 64'(obs_rob), 64'd1);
    tick();
    chk("t1_third", 64'(obs_rob), 64'd2);
    chk("t1_third_iv", 64'(obs_iv), 64'd1);
    tick();
    chk("t1_empty", 64'(obs_cnt), 64'd0);

    // Younger ready entry bypasses older waiting one; CDB wakes the older
    set_disp(5'd3, 6'd5, 1'b0, 6'd7, 1'b1); tick();
    set_disp(5'd4, 6'd8, 1'b1, 6'd0, 1'b1); tick();
    chk("t2_a_wait", 64'(obs_iv), 64'd0);
    tick();
    chk("t2_b_first", 64'(obs_rob), 64'd4);
    set_cdb(6'd5); tick();
    chk("t2_a_not_yet", 64'(obs_iv), 64'd0);
    tick();
    chk("t2_a_woken", 64'(obs_rob), 64'd3);
    chk("t2_a_woken_iv", 64'(obs_iv), 64'd1);
    tick();

    // Fill with waiting entries, refuse the ninth, wake entry 3
    for (int k = 0; k < 8; k++) begin
      set_disp(5'(8 + k), 6'(10 + k), 1'b0, 6'd0, 1'b0);
      tick();
    end
    set_disp(5'd30, 6'd0, 1'b1, 6'd0, 1'b1); tick();
    chk("t3_full_drdy", 64'(obs_drdy), 64'd0);
    chk("t3_full_cnt", 64'(obs_cnt), 64'd8);
    tick();
    chk("t3_ninth_ignored", 64'(obs_cnt), 64'd8);
    set_cdb(6'd13); tick();
    tick();
    chk("t3_entry3", 64'(obs_rob), 64'd11);
    chk("t3_still_full", 64'(obs_drdy), 64'd0);
    tick();
    chk("t3_cnt7", 64'(obs_cnt), 64'd7);
    chk("t3_drdy_back", 64'(obs_drdy), 64'd1);
    flush = 1'b1; tick();
    tick();
    chk("t3_flushed", 64'(obs_cnt), 64'd0);

    // Same-cycle CDB bypass at capture
    set_disp(5'd20, 6'd0, 1'b0, 6'd9, 1'b0); set_cdb(6'd9); tick();
    tick();
    chk("t4_bypass_iv", 64'(obs_iv), 64'd1);
    chk("t4_bypass_rob", 64'(obs_rob), 64'd20);
    tick();

    // Stall holds the oldest at the head
    q_if.issue_ready = 1'b0;
    set_disp(5'd21, 6'd0, 1'b1, 6'd0, 1'b1); tick();
    set_disp(5'd22, 6'd0, 1'b1, 6'd0, 1'b1); tick();
    tick();
    chk("t5_stall_rob", 64'(obs_rob), 64'd21);
    chk("t5_stall_cnt", 64'(obs_cnt), 64'd2);
    q_if.issue_ready = 1'b1;
    tick();
    chk("t5_rel_first", 64'(obs_rob), 64'd21);
    tick();
    chk("t5_rel_second", 64'(obs_rob), 64'd22);
    tick();

    // Flush with concurrent dispatch and issue
    q_if.issue_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_disp(5'(24 + k), 6'd0, 1'b1, 6'd0, 1'b1);
      tick();
    end
    q_if.issue_ready = 1'b1;
    flush = 1'b1;
    set_disp(5'd29, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    chk("t6_pre_cnt", 64'(obs_cnt), 64'd5);
    tick();
    chk("t6_cnt", 64'(obs_cnt), 64'd0);
    chk("t6_iv", 64'(obs_iv), 64'd0);
    chk("t6_drdy", 64'(obs_drdy), 64'd1);
    repeat (3) begin
      tick();
      chk("t6_no_ghost", 64'(obs_iv), 64'd0);
    end

    // Randomized traffic over a small tag space so wakeups collide often
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(99) < 60) begin
        set_disp(5'($urandom()), 6'($urandom_range(7)), ($urandom_range(99) < 40),
                 6'($urandom_range(7)), ($urandom_range(99) < 40));
      end
      if ($urandom_range(99) < 50) set_cdb(6'($urandom_range(7)));
      q_if.issue_ready = ($urandom_range(99) < 65);
      flush = ($urandom_range(99) < 2);
      rst   = ($urandom_range(199) < 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
